// File: rtl/dcache_wt_pkg.sv
// Shared types and address-field helpers for the write-through data cache.
package dcache_wt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_wt_array.sv
// Valid/tag/data storage: combinational read, single-word synchronous write.
module dcache_wt_array
    import dcache_wt_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    localparam int OB = off_bits(WORDS),
    localparam int IB = idx_bits(LINES),
    localparam int TW = tag_bits(LINES, WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IB-1:0] index,
    input  logic [OB-1:0] rd_offset,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [31:0]   rd_data,
    input  logic          we,
    input  logic [OB-1:0] wr_offset,
    input  logic [31:0]   wr_data,
    input  logic          set_valid,
    input  logic          clr_valid,
    input  logic [TW-1:0] wr_tag
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      data [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (set_valid) begin
            valid[index] <= 1'b1;
        end else if (clr_valid) begin
            valid[index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set_valid) begin
            tags[index] <= wr_tag;
        end
        if (we) begin
            data[index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid[index];
    assign rd_tag   = tags[index];
    assign rd_data  = data[index][rd_offset];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with
// a req/ready backing-memory port and read hit/miss counters.
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OB = off_bits(WORDS);
    localparam int IB = idx_bits(LINES);
    localparam int TW = tag_bits(LINES, WORDS);

    logic [OB-1:0] offset;
    logic [IB-1:0] index;
    logic [TW-1:0] tag;
    logic          unused_byte_bits;

    assign offset           = cpu_addr[2+OB-1:2];
    assign index            = cpu_addr[2+OB+IB-1:2+OB];
    assign tag              = cpu_addr[31:2+OB+IB];
    assign unused_byte_bits = ^cpu_addr[1:0];

    state_t        state, state_n;
    logic [OB-1:0] cnt;
    logic [OB-1:0] cnt_nx;
    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    logic [31:0]   rd_data;
    logic          arr_we;
    logic [OB-1:0] wr_offset;
    logic [31:0]   wr_data;
    logic          set_valid;
    logic          clr_valid;
    logic          hit;
    logic          rd_req;
    logic          stall_c;

    assign hit    = rd_valid && (rd_tag == tag);
    assign rd_req = cpu_read && !cpu_write;
    assign cnt_nx = cnt + 1'b1;

    dcache_wt_array #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .index    (index),
        .rd_offset(offset),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (arr_we),
        .wr_offset(wr_offset),
        .wr_data  (wr_data),
        .set_valid(set_valid),
        .clr_valid(clr_valid),
        .wr_tag   (tag)
    );

    always_comb begin
        state_n   = state;
        stall_c   = 1'b0;
        arr_we    = 1'b0;
        wr_offset = offset;
        wr_data   = cpu_wdata;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        cpu_rdata = '0;
        unique case (state)
            IDLE: begin
                if (cpu_write) begin
                    stall_c = 1'b1;
                    state_n = WRITE;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = rd_data;
                    end else begin
                        // drop the old line now so a partial refill never hits
                        stall_c   = 1'b1;
                        clr_valid = 1'b1;
                        state_n   = REFILL;
                    end
                end
            end
            REFILL: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    arr_we    = 1'b1;
                    wr_offset = cnt;
                    wr_data   = mem_rdata;
                    if (&cnt) begin
                        set_valid = 1'b1;
                        state_n   = DONE;
                    end
                end
            end
            WRITE: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    arr_we  = hit;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (rd_req) begin
                    cpu_rdata = rd_data;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign stall   = stall_c && !reset;
    assign mem_req = (state == REFILL) || (state == WRITE);
    assign mem_we  = (state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && cpu_write) begin
                mem_addr  <= {cpu_addr[31:2], 2'b00};
                mem_wdata <= cpu_wdata;
            end else if (state == IDLE && cpu_read) begin
                if (hit) begin
                    hit_count <= hit_count + 32'd1;
                end else begin
                    miss_count <= miss_count + 32'd1;
                    cnt        <= '0;
                    mem_addr   <= {tag, index, {OB{1'b0}}, 2'b00};
                end
            end
            if (state == REFILL && mem_ready) begin
                cnt      <= cnt_nx;
                mem_addr <= {tag, index, cnt_nx, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: scripted scenarios plus random traffic against
// a line-residency model and a backing-memory model.
module tb_dcache_wt;

    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int LINE_BYTES = 4 * WORDS;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    dcache_wt #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        log_q[$];
    logic [31:0] bmem [logic [31:0]];
    int          vectors = 0;
    int          errors = 0;
    int          fixed_delay = 2;

    bit          m_valid [LINES];
    logic [31:0] m_tag [LINES];
    int          m_hits;
    int          m_misses;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // which line the address maps to, and whether it is resident
    task automatic model_read(input logic [31:0] a, output bit h);
        int          idx;
        logic [31:0] tg;
        idx = int'((a / LINE_BYTES) % LINES);
        tg  = a / (LINE_BYTES * LINES);
        h   = m_valid[idx] && (m_tag[idx] == tg);
        if (h) begin
            m_hits++;
        end else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // memory responder
    initial begin
        bit busy;
        int wait_n;
        int dly;
        busy      = 1'b0;
        wait_n    = 0;
        dly       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req === 1'b1 && reset === 1'b0) begin
                if (!busy) begin
                    busy   = 1'b1;
                    wait_n = 0;
                    dly    = (fixed_delay >= 0) ? fixed_delay
                                                : int'($urandom_range(0, 2));
                end
                if (wait_n == dly) begin
                    busy      = 1'b0;
                    mem_ready = 1'b1;
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else mem_rdata = mem_rd(mem_addr);
                    log_q.push_back('{mem_we, mem_addr,
                                      mem_we ? mem_wdata : mem_rdata});
                end else begin
                    wait_n++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // caller is at posedge+1; returns at posedge+1 after the access completes
    task automatic cpu_access(input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rdata, output int n);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        n = 0;
        @(negedge clk);
        while (stall !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            vectors++;
            errors++;
            $display("FAIL stall_timeout: addr=%h still stalled after %0d cycles",
                     addr, n);
        end
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        log_q.delete();
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++;
        if ({stall, mem_req, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: stall/req/we=%b expected 000",
                     {stall, mem_req, mem_we});
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h wdata=%h expected 0/0",
                     mem_addr, mem_wdata);
        end
        vectors++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", cpu_rdata);
        end
        vectors++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d expected 0/0",
                     hit_count, miss_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_refill();
        logic [31:0] rd;
        int          n;
        bit          h;
        fixed_delay = 2;
        for (int i = 0; i < 4; i++) bmem[32'h100 + 4 * i] = 32'hA0 + i;
        log_q.delete();
        model_read(32'h100, h);
        cpu_access(1'b1, 1'b0, 32'h100, 32'h0, rd, n);
        vectors++;
        if (n !== 13) begin
            errors++;
            $display("FAIL refill_stall: got %0d cycles expected 13", n);
        end
        vectors++;
        if (log_q.size() !== 4) begin
            errors++;
            $display("FAIL refill_count: got %0d mem ops expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (log_q[i].we !== 1'b0 || log_q[i].addr !== 32'h100 + 4 * i) begin
                    errors++;
                    $display("FAIL refill_addr%0d: we=%b addr=%h expected 0/%h",
                             i, log_q[i].we, log_q[i].addr, 32'h100 + 4 * i);
                end
            end
        end
        vectors++;
        if (rd !== 32'hA0) begin
            errors++;
            $display("FAIL refill_rdata: got %h expected a0", rd);
        end
        vectors++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL refill_counters: hit=%0d miss=%0d expected 0/1",
                     hit_count, miss_count);
        end
        log_q.delete();
        model_read(32'h108, h);
        cpu_access(1'b1, 1'b0, 32'h108, 32'h0, rd, n);
        vectors++;
        if (n !== 0 || rd !== 32'hA2) begin
            errors++;
            $display("FAIL hit_read: stall=%0d rdata=%h expected 0/a2", n, rd);
        end
        vectors++;
        if (hit_count !== 32'd1 || log_q.size() !== 0) begin
            errors++;
            $display("FAIL hit_counters: hit=%0d memops=%0d expected 1/0",
                     hit_count, log_q.size());
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd;
        int          n;
        bit          h;
        fixed_delay = 1;
        log_q.delete();
        cpu_access(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, rd, n);
        vectors++;
        if (n !== 3) begin
            errors++;
            $display("FAIL write_stall: got %0d cycles expected 3", n);
        end
        vectors++;
        if (log_q.size() !== 1 || log_q[0].we !== 1'b1 ||
            log_q[0].addr !== 32'h104 || log_q[0].data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_memop: n=%0d we=%b addr=%h data=%h expected 1/1/104/deadbeef",
                     log_q.size(), log_q[0].we, log_q[0].addr, log_q[0].data);
        end
        log_q.delete();
        model_read(32'h104, h);
        cpu_access(1'b1, 1'b0, 32'h104, 32'h0, rd, n);
        vectors++;
        if (n !== 0 || rd !== 32'hDEADBEEF || log_q.size() !== 0) begin
            errors++;
            $display("FAIL write_hit_read: stall=%0d rdata=%h memops=%0d expected 0/deadbeef/0",
                     n, rd, log_q.size());
        end
        vectors++;
        if (hit_count !== m_hits || miss_count !== m_misses) begin
            errors++;
            $display("FAIL write_hit_counters: hit=%0d miss=%0d expected %0d/%0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd;
        int          n;
        bit          h;
        log_q.delete();
        cpu_access(1'b0, 1'b1, 32'h2000, 32'h12345678, rd, n);
        vectors++;
        if (log_q.size() !== 1 || log_q[0].we !== 1'b1 || log_q[0].addr !== 32'h2000) begin
            errors++;
            $display("FAIL wmiss_memop: n=%0d we=%b addr=%h expected 1/1/2000",
                     log_q.size(), log_q[0].we, log_q[0].addr);
        end
        log_q.delete();
        model_read(32'h2000, h);
        cpu_access(1'b1, 1'b0, 32'h2000, 32'h0, rd, n);
        vectors++;
        if (h || n === 0 || log_q.size() !== 4) begin
            errors++;
            $display("FAIL wmiss_refill: stall=%0d memops=%0d expected miss with 4 reads",
                     n, log_q.size());
        end
        vectors++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL wmiss_rdata: got %h expected 12345678", rd);
        end
        vectors++;
        if (miss_count !== m_misses || hit_count !== m_hits) begin
            errors++;
            $display("FAIL wmiss_counters: hit=%0d miss=%0d expected %0d/%0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] rd;
        int          n;
        bit          h;
        logic [31:0] seq [3];
        seq = '{32'h100, 32'h500, 32'h100};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            model_read(seq[i], h);
            cpu_access(1'b1, 1'b0, seq[i], 32'h0, rd, n);
            vectors++;
            if (rd !== mem_rd(seq[i]) || n === 0) begin
                errors++;
                $display("FAIL conflict_read%0d: rdata=%h stall=%0d expected %h with miss",
                         i, rd, n, mem_rd(seq[i]));
            end
        end
        vectors++;
        if (hit_count !== 32'd0 || miss_count !== 32'd3) begin
            errors++;
            $display("FAIL conflict_counters: hit=%0d miss=%0d expected 0/3",
                     hit_count, miss_count);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd;
        int          n;
        int          t;
        bit          h;
        apply_reset();
        fixed_delay = 1;
        cpu_read  = 1'b1;
        cpu_addr  = 32'h100;
        t = 0;
        while (log_q.size() < 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (t >= 100) begin
            vectors++;
            errors++;
            $display("FAIL midrst_timeout: %0d words after %0d cycles", log_q.size(), t);
        end
        #1;
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: mem_req=%b stall=%b expected 0/0",
                     mem_req, stall);
        end
        @(posedge clk);
        #1;
        model_clear();
        log_q.delete();
        model_read(32'h100, h);
        cpu_access(1'b1, 1'b0, 32'h100, 32'h0, rd, n);
        vectors++;
        if (n !== 9 || log_q.size() !== 4) begin
            errors++;
            $display("FAIL midrst_refill: stall=%0d memops=%0d expected 9/4",
                     n, log_q.size());
        end
        vectors++;
        if (rd !== mem_rd(32'h100) || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL midrst_rdata: rdata=%h miss=%0d expected %h/1",
                     rd, miss_count, mem_rd(32'h100));
        end
    endtask

    task automatic test_rw_both();
        logic [31:0] rd;
        int          n;
        bit          h;
        log_q.delete();
        cpu_access(1'b1, 1'b1, 32'h100, 32'h5555AAAA, rd, n);
        vectors++;
        if (log_q.size() !== 1 || log_q[0].we !== 1'b1 ||
            log_q[0].data !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL both_memop: n=%0d we=%b data=%h expected 1/1/5555aaaa",
                     log_q.size(), log_q[0].we, log_q[0].data);
        end
        vectors++;
        if (hit_count !== m_hits || miss_count !== m_misses) begin
            errors++;
            $display("FAIL both_counters: hit=%0d miss=%0d expected %0d/%0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
        model_read(32'h100, h);
        cpu_access(1'b1, 1'b0, 32'h100, 32'h0, rd, n);
        vectors++;
        if (rd !== 32'h5555AAAA || n !== 0) begin
            errors++;
            $display("FAIL both_readback: rdata=%h stall=%0d expected 5555aaaa/0",
                     rd, n);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        int          n;
        int          op;
        bit          h;
        apply_reset();
        fixed_delay = -1;
        for (int k = 0; k < 300; k++) begin
            a  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) |
                 ($urandom_range(0, 3) << 2);
            op = int'($urandom_range(0, 9));
            log_q.delete();
            if (op < 3) begin
                wd = $urandom;
                cpu_access(1'b0, 1'b1, a, wd, rd, n);
                vectors++;
                if (log_q.size() !== 1 || log_q[0].addr !== a || log_q[0].data !== wd) begin
                    errors++;
                    $display("FAIL rand_write%0d: n=%0d addr=%h data=%h expected 1/%h/%h",
                             k, log_q.size(), log_q[0].addr, log_q[0].data, a, wd);
                end
            end else begin
                exp = mem_rd(a);
                model_read(a, h);
                cpu_access(1'b1, 1'b0, a, 32'h0, rd, n);
                vectors++;
                if (rd !== exp) begin
                    errors++;
                    $display("FAIL rand_rdata%0d: addr=%h got %h expected %h",
                             k, a, rd, exp);
                end
                vectors++;
                if ((n == 0) !== h) begin
                    errors++;
                    $display("FAIL rand_hit%0d: addr=%h stall=%0d expected hit=%0d",
                             k, a, n, h);
                end
            end
        end
        vectors++;
        if (hit_count !== m_hits || miss_count !== m_misses) begin
            errors++;
            $display("FAIL rand_counters: hit=%0d miss=%0d expected %0d/%0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        test_reset();
        test_refill();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_refill();
        test_rw_both();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the pipelined CPU's EX/MEM register. It replaces the single-cycle data memory on the CPU side and talks to a slower backing memory through a req/ready handshake.
- Asserts `stall` to freeze the pipeline on read misses and on all writes.
- Keeps hit/miss performance counters.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_addr  in  32  byte address from EX/MEM ALU result; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_read  in  1  load request (MemRead)
- cpu_write  in  1  store request (MemWrite)
- cpu_rdata  out  32  load data
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_req  out  1  backing-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned address; bits [1:0] = 0
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  completes the current request in this cycle
- hit_count  out  32  read hits since reset
- miss_count  out  32  read misses since reset

Behaviour:
- Address split, with OB=log2(WORDS) and IB=log2(LINES):
  - offset = addr[2+OB-1:2]
  - index = addr[2+OB+IB-1:2+OB]
  - tag = the remaining upper bits
- Storage per line: valid, tag, WORDS×32 data. Lookup is combinational: hit = valid[index] && tag match.
- Reset state: all valid=0, state IDLE, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, counters=0.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE:
  - No request: stall=0, cpu_rdata=0.
  - cpu_read & hit: cpu_rdata = data[index][offset] combinationally in the same cycle; stall=0; hit_count++. Zero-latency, matching the old data memory.
  - cpu_read & miss: stall=1 combinationally in the same cycle; miss_count++ (once per miss); word counter cnt=0; go to REFILL.
  - cpu_write: stall=1 combinationally; go to WRITE. cpu_write has priority if both cpu_write and cpu_read are high.
- REFILL:
  - stall=1, mem_req=1, mem_we=0, mem_addr={tag,index,cnt,2'b00}.
  - On mem_ready: data[index][cnt] ← mem_rdata, then cnt++.
  - When the last word (cnt=WORDS-1) is accepted: valid[index]←1, tag[index]←tag; go to DONE.
  - The line's valid bit is cleared on entry to REFILL, so a partial line is never hit.
- WRITE:
  - stall=1, mem_req=1, mem_we=1, mem_addr=word-aligned cpu_addr, mem_wdata=cpu_wdata.
  - On mem_ready: if hit, data[index][offset] ← cpu_wdata (a miss allocates nothing); go to DONE.
- DONE:
  - stall=0 for exactly one cycle.
  - For a read, cpu_rdata = data[index][offset], which now hits; no counter change.
  - Go to IDLE.
- The CPU holds cpu_addr, cpu_wdata, cpu_read and cpu_write stable while stall=1. Behaviour is undefined otherwise.
- Memory-side signals are registered. mem_req drops in the cycle after the accepting mem_ready edge. mem_ready while mem_req=0 is ignored.
- Reset mid-operation: the next state is IDLE and all lines are invalidated. mem_req=0 and stall=0 from the first post-reset cycle. The partially refilled line is never valid.
- Counters wrap modulo 2^32.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/REFILL/WRITE/DONE);
  - address field-width helper functions derived from LINES/WORDS.
- One natural sub-module: dcache_wt_array. It holds the valid/tag/data storage, with a combinational read port and a synchronous single-word write port, and clears valid on reset.
- The FSM and counters stay in the top module.

Test Plan:
- After reset, read 0x100; memory returns 0xA0..0xA3 with a 2-cycle ready delay → stall high in the request cycle; four mem reads at 0x100, 0x104, 0x108, 0x10C; DONE returns rdata=0xA0; miss_count=1. A following read of 0x108 → same-cycle rdata=0xA2, stall=0, hit_count=1.
- Write 0x104←0xDEADBEEF to the cached line → mem_we=1, mem_addr=0x104; stall drops in DONE. A following read of 0x104 hits with 0xDEADBEEF and issues no mem_req.
- Write to uncached 0x2000 → memory write only. A following read of 0x2000 misses (miss_count increments) and refills.
- Conflict: read 0x100, then read 0x500 (same index, different tag), then read 0x100 → three misses, counters hit=0, miss=3.
- Assert reset during REFILL after 2 words → mem_req=0 and stall=0 in the next cycle. A re-read of 0x100 misses and refills all 4 words.
- cpu_read and cpu_write high together at 0x100 → handled as a write (mem_we=1); hit_count and miss_count unchanged.
